// File: rtl/jk_excitation_driver.sv
// Converts a stream of requested bits into J/K excitation for an external JK flop,
// then reads the flop back one cycle later and records any mismatch.
module jk_excitation_driver #(
   parameter int CNT_W       = 8,
   parameter bit TOGGLE_PREF = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tgt_valid,
   input  logic             tgt_bit,
   output logic             tgt_ready,
   output logic             j,
   output logic             k,
   input  logic             q,
   input  logic             clear,
   output logic             err,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] bit_count
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DRIVE = 2'd1;
   localparam logic [1:0] CHECK = 2'd2;

   localparam logic             DONT_CARE = TOGGLE_PREF;
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   logic [1:0]       r_state;
   logic             r_tgt;
   logic             r_j;
   logic             r_k;
   logic             r_err;
   logic [CNT_W-1:0] r_errCount;
   logic [CNT_W-1:0] r_bitCount;

   logic w_accept;
   logic w_mismatch;
   logic w_jNext;
   logic w_kNext;

   assign w_accept   = tgt_valid && (r_state == IDLE);
   assign w_mismatch = (r_state == CHECK) && (q != r_tgt);

   // JK excitation table; the don't-care entries take the TOGGLE_PREF value.
   assign w_jNext = q ? DONT_CARE : tgt_bit;
   assign w_kNext = q ? ~tgt_bit  : DONT_CARE;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_tgt   <= 1'b0;
         r_j     <= 1'b0;
         r_k     <= 1'b0;
      end else begin
         r_j <= 1'b0;
         r_k <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_tgt   <= tgt_bit;
                  r_j     <= w_jNext;
                  r_k     <= w_kNext;
                  r_state <= DRIVE;
               end
            end
            DRIVE:   r_state <= CHECK;
            CHECK:   r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // A mismatch in the same cycle as clear wins and restarts the count at one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err      <= 1'b0;
         r_errCount <= '0;
      end else if (w_mismatch) begin
         r_err <= 1'b1;
         if (clear) begin
            r_errCount <= CNT_ONE;
         end else if (r_errCount != CNT_MAX) begin
            r_errCount <= r_errCount + CNT_ONE;
         end
      end else if (clear) begin
         r_err      <= 1'b0;
         r_errCount <= '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_bitCount <= '0;
      end else if (r_state == CHECK) begin
         r_bitCount <= r_bitCount + CNT_ONE;
      end
   end

   assign tgt_ready = (r_state == IDLE);
   assign j         = r_j;
   assign k         = r_k;
   assign err       = r_err;
   assign err_count = r_errCount;
   assign bit_count = r_bitCount;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Self-checking bench: three driver variants (set/reset style, toggle style, 2-bit counters)
// share one stimulus stream, each steering its own behavioural JK flop.
module tb_jk_excitation_driver;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic tgt_valid = 1'b0;
   logic tgt_bit = 1'b0;
   logic clear = 1'b0;
   logic flopRstN = 1'b0;

   logic rdy[3];
   logic jv[3];
   logic kv[3];
   logic ev[3];
   logic fq0, fq1, fq2;
   logic [7:0] ec0, ec1, bc0, bc1;
   logic [1:0] ec2, bc2;

   int errors = 0;
   int checks = 0;

   int modelQ;
   int errM[3];
   int ecM[3];
   int bcM[3];
   int cw[3];
   bit pref[3];
   logic lastJ[3];
   logic lastK[3];

   typedef struct {
      bit tgt;
      bit j0;
      bit k0;
      bit j1;
      bit k1;
   } vec_t;
   vec_t streamTab[5];

   always #5 clk = ~clk;

   jk_excitation_driver #(.CNT_W(8), .TOGGLE_PREF(1'b0)) dut0 (
      .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
      .tgt_ready(rdy[0]), .j(jv[0]), .k(kv[0]), .q(fq0), .clear(clear),
      .err(ev[0]), .err_count(ec0), .bit_count(bc0));

   jk_excitation_driver #(.CNT_W(8), .TOGGLE_PREF(1'b1)) dut1 (
      .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
      .tgt_ready(rdy[1]), .j(jv[1]), .k(kv[1]), .q(fq1), .clear(clear),
      .err(ev[1]), .err_count(ec1), .bit_count(bc1));

   jk_excitation_driver #(.CNT_W(2), .TOGGLE_PREF(1'b0)) dut2 (
      .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
      .tgt_ready(rdy[2]), .j(jv[2]), .k(kv[2]), .q(fq2), .clear(clear),
      .err(ev[2]), .err_count(ec2), .bit_count(bc2));

   // Behavioural external JK flops with their own async reset (q forced to 0).
   function automatic logic jkNext(logic qq, logic jj, logic kk);
      case ({jj, kk})
         2'b00:   return qq;
         2'b01:   return 1'b0;
         2'b10:   return 1'b1;
         default: return ~qq;
      endcase
   endfunction

   always @(posedge clk or negedge flopRstN) begin
      if (!flopRstN) fq0 <= 1'b0; else fq0 <= jkNext(fq0, jv[0], kv[0]);
   end
   always @(posedge clk or negedge flopRstN) begin
      if (!flopRstN) fq1 <= 1'b0; else fq1 <= jkNext(fq1, jv[1], kv[1]);
   end
   always @(posedge clk or negedge flopRstN) begin
      if (!flopRstN) fq2 <= 1'b0; else fq2 <= jkNext(fq2, jv[2], kv[2]);
   end

   // Excitation straight from the textbook table, X replaced by the preference bit.
   function automatic logic [1:0] expJK(bit p, bit qq, bit t);
      case ({qq, t})
         2'b00:   return {1'b0, p};
         2'b01:   return {1'b1, p};
         2'b10:   return {p, 1'b1};
         default: return {p, 1'b0};
      endcase
   endfunction

   function automatic int getEc(int i);
      case (i)
         0:       return int'(ec0);
         1:       return int'(ec1);
         default: return int'(ec2);
      endcase
   endfunction

   function automatic int getBc(int i);
      case (i)
         0:       return int'(bc0);
         1:       return int'(bc1);
         default: return int'(bc2);
      endcase
   endfunction

   function automatic int getFq(int i);
      case (i)
         0:       return int'(fq0);
         1:       return int'(fq1);
         default: return int'(fq2);
      endcase
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic checkStatus(input string tag);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("%s_err%0d", tag, i), int'(ev[i]), errM[i]);
         checkOutput($sformatf("%s_errCount%0d", tag, i), getEc(i), ecM[i]);
         checkOutput($sformatf("%s_bitCount%0d", tag, i), getBc(i), bcM[i]);
         checkOutput($sformatf("%s_ready%0d", tag, i), int'(rdy[i]), 1);
      end
   endtask

   task automatic applyReset();
      reset = 1'b0;
      flopRstN = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      flopRstN = 1'b1;
      modelQ = 0;
      for (int i = 0; i < 3; i++) begin
         errM[i] = 0;
         ecM[i] = 0;
         bcM[i] = 0;
         checkOutput($sformatf("rst_j%0d", i), int'(jv[i]), 0);
         checkOutput($sformatf("rst_k%0d", i), int'(kv[i]), 0);
      end
      checkStatus("rst");
   endtask

   // One full request: accept, one DRIVE cycle, one CHECK cycle, then status check.
   task automatic applyStimulus(input bit b, input bit stuck, input bit doClear);
      logic [1:0] e;
      int waitCyc;
      int qAfter;
      bit mism;
      @(negedge clk);
      if (stuck) begin
         flopRstN = 1'b0;
         modelQ = 0;
      end
      tgt_valid = 1'b1;
      tgt_bit = b;
      waitCyc = 0;
      while (!rdy[0] && waitCyc < 10) begin
         @(negedge clk);
         waitCyc++;
      end
      checkOutput("readyIdle", int'(rdy[0]), 1);
      if (!rdy[0]) begin
         tgt_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      tgt_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         e = expJK(pref[i], modelQ[0], b);
         lastJ[i] = jv[i];
         lastK[i] = kv[i];
         checkOutput($sformatf("driveJ%0d", i), int'(jv[i]), int'(e[1]));
         checkOutput($sformatf("driveK%0d", i), int'(kv[i]), int'(e[0]));
         checkOutput($sformatf("readyDrive%0d", i), int'(rdy[i]), 0);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("checkJK%0d", i), int'({jv[i], kv[i]}), 0);
         checkOutput($sformatf("readyCheck%0d", i), int'(rdy[i]), 0);
      end
      if (doClear) clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      qAfter = stuck ? 0 : int'(b);
      mism = (qAfter != int'(b));
      modelQ = qAfter;
      for (int i = 0; i < 3; i++) begin
         bcM[i] = (bcM[i] + 1) % (1 << cw[i]);
         if (mism) begin
            errM[i] = 1;
            ecM[i] = doClear ? 1 : ((ecM[i] + 1 > (1 << cw[i]) - 1) ? (1 << cw[i]) - 1 : ecM[i] + 1);
         end else if (doClear) begin
            errM[i] = 0;
            ecM[i] = 0;
         end
      end
      if (stuck) flopRstN = 1'b1;
      checkStatus("post");
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired before end of test");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int acceptCyc[4];
      int accepts;
      bit rb, rs, rc;

      cw = '{8, 8, 2};
      pref = '{1'b0, 1'b1, 1'b0};
      streamTab[0] = '{tgt: 1'b1, j0: 1'b1, k0: 1'b0, j1: 1'b1, k1: 1'b1};
      streamTab[1] = '{tgt: 1'b1, j0: 1'b0, k0: 1'b0, j1: 1'b1, k1: 1'b0};
      streamTab[2] = '{tgt: 1'b0, j0: 1'b0, k0: 1'b1, j1: 1'b1, k1: 1'b1};
      streamTab[3] = '{tgt: 1'b0, j0: 1'b0, k0: 1'b0, j1: 1'b0, k1: 1'b1};
      streamTab[4] = '{tgt: 1'b1, j0: 1'b1, k0: 1'b0, j1: 1'b1, k1: 1'b1};

      applyReset();

      // Reset during DRIVE drops the pending bit.
      @(negedge clk);
      tgt_valid = 1'b1;
      tgt_bit = 1'b1;
      @(posedge clk);
      #1;
      tgt_valid = 1'b0;
      checkOutput("midDriveJ", int'(jv[0]), 1);
      reset = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("midRstJK%0d", i), int'({jv[i], kv[i]}), 0);
         checkOutput($sformatf("midRstReady%0d", i), int'(rdy[i]), 1);
         checkOutput($sformatf("midRstBits%0d", i), getBc(i), 0);
      end
      @(negedge clk);
      reset = 1'b1;

      // Directed stream 1,1,0,0,1 from q=0.
      applyReset();
      for (int n = 0; n < 5; n++) begin
         applyStimulus(streamTab[n].tgt, 1'b0, 1'b0);
         checkOutput($sformatf("tabJ0_%0d", n), int'(lastJ[0]), int'(streamTab[n].j0));
         checkOutput($sformatf("tabK0_%0d", n), int'(lastK[0]), int'(streamTab[n].k0));
         checkOutput($sformatf("tabJ1_%0d", n), int'(lastJ[1]), int'(streamTab[n].j1));
         checkOutput($sformatf("tabK1_%0d", n), int'(lastK[1]), int'(streamTab[n].k1));
         checkOutput($sformatf("tabQ0_%0d", n), getFq(0), int'(streamTab[n].tgt));
         checkOutput($sformatf("tabQ1_%0d", n), getFq(1), int'(streamTab[n].tgt));
      end
      checkOutput("streamBits", getBc(0), 5);
      checkOutput("streamErr", int'(ev[0] | ev[1]), 0);

      // Back-to-back requests with tgt_valid held high.
      @(negedge clk);
      tgt_valid = 1'b1;
      tgt_bit = 1'b1;
      accepts = 0;
      for (int c = 0; c < 40 && accepts < 4; c++) begin
         if (c > 0) @(negedge clk);
         if (rdy[0]) begin
            acceptCyc[accepts] = c;
            accepts++;
         end
      end
      @(posedge clk);
      #1;
      tgt_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("heldAccepts", accepts, 4);
      for (int a = 1; a < 4; a++) begin
         if (a < accepts) checkOutput($sformatf("acceptGap%0d", a), acceptCyc[a] - acceptCyc[a-1], 3);
      end
      modelQ = 1;
      for (int i = 0; i < 3; i++) bcM[i] = (bcM[i] + accepts) % (1 << cw[i]);
      checkStatus("held");

      // Stuck-at-0 flop: three mismatches, then a clear that collides with a fourth.
      applyReset();
      for (int n = 0; n < 3; n++) applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("stuckErr", int'(ev[0]), 1);
      checkOutput("stuckCount", getEc(0), 3);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("clearCollideErr", int'(ev[0]), 1);
      checkOutput("clearCollideCount", getEc(0), 1);

      // Two-bit counters: saturating errors, wrapping bits.
      applyReset();
      for (int n = 0; n < 5; n++) applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("satErrCount", getEc(2), 3);
      checkOutput("wrapBitCount", getBc(2), 1);
      checkOutput("wideErrCount", getEc(0), 5);

      // Random stream against the model, with random flop faults and clears.
      applyReset();
      for (int n = 0; n < 40; n++) begin
         rb = 1'($urandom);
         rs = ($urandom_range(0, 3) == 0);
         rc = ($urandom_range(0, 4) == 0);
         applyStimulus(rb, rs, rc);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/jk_excitation_driver.md
# jk_excitation_driver

Drives the J/K inputs of an external JK flip-flop so that its output follows a requested bit stream. It is the driving end of the JK flop interface. Each requested bit is accepted over a valid/ready handshake and converted into J/K excitation from the flop's present `q`. The block then reads `q` back after the flop's clock edge and flags any mismatch. It sits in front of `jk_flipflop` instances in the latches-and-flops area, sharing their clock, and replaces hand-written J/K stimulus sequences.

## Interface
Parameters:
- `CNT_W`, 8, width of `err_count` and `bit_count`
- `TOGGLE_PREF`, 0, policy for excitation don't-cares: 0 drives X as 0 (set/reset style), 1 drives X as 1 (toggle style)

Ports:
- `clk`  in  1  single clock; all registers and the external flop update on its rising edge
- `reset`  in  1  asynchronous, active-low; 0 forces all registers to reset values immediately
- `tgt_valid`  in  1  requested bit present
- `tgt_bit`  in  1  requested next value of `q`
- `tgt_ready`  out  1  block can accept a bit
- `j`, `k`  out  1 each  excitation to the external flop
- `q`  in  1  external flop output, fed back
- `clear`  in  1  synchronous clear of `err` and `err_count`
- `err`  out  1  sticky mismatch flag
- `err_count`  out  CNT_W  mismatches, saturating
- `bit_count`  out  CNT_W  bits completed, wrapping

## Operation
- FSM states: IDLE, DRIVE, CHECK. Reset state is IDLE.
- Reset values: `j=0`, `k=0`, `err=0`, `err_count=0`, `bit_count=0`. `tgt_ready=1`, since it decodes IDLE.
- `tgt_ready` = (state == IDLE). It is combinational from state only.
- IDLE: `j=k=0`, so the flop holds. On an edge with `tgt_valid && tgt_ready`:
  - capture `tgt_bit` into `tgt_r`;
  - register `j`/`k` from the present `q` and `tgt_bit` using the excitation rules below;
  - go to DRIVE.
- Excitation (present q -> target : j k):
  - 0->0 : 0, X
  - 0->1 : 1, X
  - 1->0 : X, 1
  - 1->1 : X, 0
  - X = `TOGGLE_PREF`.
- DRIVE: `j`/`k` held for exactly one cycle. The external flop updates on the edge that ends DRIVE. On that edge the block sets `j=k=0` and goes to CHECK.
- CHECK: `j=k=0`. `q` is compared with `tgt_r` and sampled on the edge ending CHECK. On that edge:
  - `bit_count` increments, modulo 2^CNT_W;
  - on mismatch, `err` is set and `err_count` increments, saturating at 2^CNT_W-1;
  - state returns to IDLE.
- `clear` (any state) zeroes `err` and `err_count` on the next edge.
  - Simultaneous `clear` and CHECK mismatch: the mismatch wins, giving `err=1` and `err_count=1`.
  - `clear` does not affect `bit_count`.
- `tgt_valid` with `tgt_ready=0` is ignored and is not queued. The upstream must hold `tgt_valid` until accepted.
- Reset asserted mid-operation (DRIVE or CHECK): immediate return to IDLE with `j=k=0`. The pending bit is dropped and not counted.

## Timing
- Accept at edge N. `j`/`k` are valid from N until N+1. The flop updates at N+1. The check is sampled at N+2.
- Next accept is possible at N+3 at the earliest. Throughput is 1 bit per 3 cycles.
- `err` and counters update at N+2 and are visible after that edge.
- `j`/`k` are registered outputs: glitch-free and never 1 outside DRIVE.
- The external flop's own reset is separate. While it is held in reset, any requested 1 reports a mismatch.

## Test plan
- Reset: hold `reset=0` for 2 cycles, then release -> `j=k=0`, `tgt_ready=1`, `err=0`, both counts 0. Re-assert `reset=0` mid-DRIVE -> `j=k=0` immediately and `bit_count` unchanged.
- Stream 1,1,0,0,1 into a working `jk_flipflop` starting at q=0, with `TOGGLE_PREF=0` -> (j,k) per bit = (1,0),(0,0),(0,1),(0,0),(1,0); q follows; `bit_count=5`; `err=0`.
- Same stream with `TOGGLE_PREF=1` -> (j,k) = (1,1),(1,0),(1,1),(0,1),(1,1); q follows; `err=0`.
- Hold `tgt_valid=1` continuously for 4 bits -> accepts occur exactly 3 cycles apart, and `tgt_ready` is low in DRIVE and CHECK.
- Fault: force `q` stuck at 0 and request 1 three times -> `err=1` and `err_count=3`. Pulse `clear` in the same cycle as a 4th mismatch check -> `err=1` and `err_count=1`.
- Saturation with `CNT_W=2`: 5 forced mismatches -> `err_count=3` and `bit_count` wraps to 1.
